history_bus_reader: RTL



---
 rtl/history_bus_reader_if.sv | 26 ++
 rtl/history_bus_reader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/history_bus_reader_if.sv
// Shared read bus between the history-register bank and the sequencing reader,
// together with the scan control strobes and the snapshot output.
interface history_bus_reader_if #(
   parameter int NrOfBits = 1,
   parameter int NrOfRegs = 8
);
   logic                         Tick;
   logic                         Start;
   logic [NrOfBits-1:0]          BusIn;
   logic [NrOfRegs-1:0]          cs;
   logic                         Busy;
   logic [NrOfRegs*NrOfBits-1:0] Data;
   logic                         Valid;

   // Handshake: Start is a level request seen only while Busy=0; Valid is a
   // single-cycle strobe qualifying Data, with no back-pressure from the consumer.
   modport master (
      input  Tick, Start, BusIn,
      output cs, Busy, Data, Valid
   );

   modport slave (
      output Tick, Start, BusIn,
      input  cs, Busy, Data, Valid
   );
endinterface

// File: rtl/history_bus_reader.sv
// Scans a bank of tri-state history registers one at a time over a shared bus and
// publishes a full snapshot with a one-cycle Valid. HISTORY_READER_GAP_EN adds a turnaround cycle.
module history_bus_reader #(
   parameter int NrOfBits = 1,
   parameter int NrOfRegs = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   history_bus_reader_if.master bus,
   output logic [2:0]           state_dbg
);

   localparam int IDX_W = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1;
   localparam int DW    = NrOfRegs * NrOfBits;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NrOfRegs - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_SAMPLE = 3'd2;
`ifdef HISTORY_READER_GAP_EN
   localparam logic [2:0] ST_GAP    = 3'd3;
`endif
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0]          state_q, state_nxt;
   logic [IDX_W-1:0]    idx_q, idx_nxt;
   logic [DW-1:0]       shadow_q, shadow_nxt;
   logic [DW-1:0]       data_q, data_nxt;
   logic [NrOfRegs-1:0] cs_q, cs_nxt;
   logic                busy_q;
   logic                valid_q;

   always_comb begin
      state_nxt  = state_q;
      idx_nxt    = idx_q;
      shadow_nxt = shadow_q;
      data_nxt   = data_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               state_nxt = ST_SELECT;
               idx_nxt   = '0;
            end
         end
         ST_SELECT: begin
            if (bus.Tick) state_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (bus.Tick) begin
               for (int i = 0; i < NrOfRegs; i++) begin
                  if (idx_q == i[IDX_W-1:0]) shadow_nxt[i*NrOfBits +: NrOfBits] = bus.BusIn;
               end
               if (idx_q == LAST_IDX) begin
                  // Data is loaded with the final slot merged so it is visible in DONE.
                  state_nxt = ST_DONE;
                  data_nxt  = shadow_nxt;
               end else begin
`ifdef HISTORY_READER_GAP_EN
                  state_nxt = ST_GAP;
`else
                  state_nxt = ST_SELECT;
                  idx_nxt   = idx_q + IDX_W'(1);
`endif
               end
            end
         end
`ifdef HISTORY_READER_GAP_EN
         ST_GAP: begin
            if (bus.Tick) begin
               state_nxt = ST_SELECT;
               idx_nxt   = idx_q + IDX_W'(1);
            end
         end
`endif
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered, so they are derived from the next state.
   always_comb begin
      cs_nxt = '1;
      if (state_nxt == ST_SELECT || state_nxt == ST_SAMPLE) begin
         for (int i = 0; i < NrOfRegs; i++) begin
            if (idx_nxt == i[IDX_W-1:0]) cs_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         cs_q     <= '1;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         idx_q    <= idx_nxt;
         shadow_q <= shadow_nxt;
         data_q   <= data_nxt;
         cs_q     <= cs_nxt;
         busy_q   <= (state_nxt != ST_IDLE);
         valid_q  <= (state_nxt == ST_DONE);
      end
   end

   assign bus.cs    = cs_q;
   assign bus.Busy  = busy_q;
   assign bus.Data  = data_q;
   assign bus.Valid = valid_q;
   assign state_dbg = state_q;

endmodule
